// File: rtl/sram22_sram_model_pipelined_pkg.sv
// Shared definitions for the sram22 behavioural macro model:
// read-during-write modes, sweep states and lane geometry.
package sram22_model_pkg;

  localparam int RDW_X   = 0;
  localparam int RDW_NEW = 1;
  localparam int RDW_OLD = 2;

  typedef enum logic {
    INIT,
    READY
  } init_state_e;

  function automatic int lane_width(
    input int dw,
    input int mw
  );
    return dw / mw;
  endfunction

endpackage

// File: rtl/sram22_sram_model_pipelined_if.sv
// Single-port access bus of the sram22 model: request side driven by
// the controller, read data, qualifier and busy flag from the macro.
interface sram22_sram_model_pipelined_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int WMASK_WIDTH = 4
);

  logic                   ce;
  logic                   we;
  logic [WMASK_WIDTH-1:0] wmask;
  logic [ADDR_WIDTH-1:0]  addr;
  logic [DATA_WIDTH-1:0]  din;
  logic [DATA_WIDTH-1:0]  dout;
  logic                   dout_valid;
  logic                   busy;

  modport master (
    output ce, we, wmask, addr, din,
    input  dout, dout_valid, busy
  );

  modport slave (
    input  ce, we, wmask, addr, din,
    output dout, dout_valid, busy
  );

endinterface

// File: rtl/sram22_sram_model_pipelined_init_seq.sv
// Post-reset zero-fill sequencer: walks every word address once,
// holding busy until the last word has been cleared.
module sram22_init_seq
  import sram22_model_pkg::*;
#(
  parameter int ADDR_WIDTH    = 10,
  parameter int INIT_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  rstb,
  output logic                  busy,
  output logic                  init_we,
  output logic [ADDR_WIDTH-1:0] init_addr
);

  init_state_e           state;
  logic [ADDR_WIDTH-1:0] ptr;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= (INIT_ON_RESET != 0) ? INIT : READY;
      ptr   <= '0;
      busy  <= (INIT_ON_RESET != 0);
    end else if (state == INIT) begin
      ptr <= ptr + 1'b1;
      // last word cleared on this edge
      if (&ptr) begin
        state <= READY;
        busy  <= 1'b0;
      end
    end
  end

  assign init_we   = (state == INIT);
  assign init_addr = ptr;

endmodule

// File: rtl/sram22_sram_model_pipelined.sv
// Parametrised behavioural SRAM model with optional output flop,
// selectable read-during-write data and post-reset zero sweep.
module sram22_sram_model_pipelined
  import sram22_model_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 10,
  parameter int WMASK_WIDTH   = 4,
  parameter int OUT_REG       = 0,
  parameter int RDW_MODE      = 0,
  parameter int INIT_ON_RESET = 1
) (
  input logic clk,
  input logic rstb,
  sram22_sram_model_pipelined_if.slave bus
);

  localparam int LW    = lane_width(DATA_WIDTH, WMASK_WIDTH);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  if (DATA_WIDTH % WMASK_WIDTH != 0) begin : g_bad_mask
    $error("DATA_WIDTH not a multiple of WMASK_WIDTH");
  end
  if (RDW_MODE > 2) begin : g_bad_rdw
    $error("RDW_MODE out of range");
  end

  logic                  busy;
  logic                  init_we;
  logic [ADDR_WIDTH-1:0] init_addr;

  sram22_init_seq #(
    .ADDR_WIDTH    (ADDR_WIDTH),
    .INIT_ON_RESET (INIT_ON_RESET)
  ) u_init_seq (
    .clk       (clk),
    .rstb      (rstb),
    .busy      (busy),
    .init_we   (init_we),
    .init_addr (init_addr)
  );

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rd_word;
  logic [DATA_WIDTH-1:0] merged;
  logic [DATA_WIDTH-1:0] rdw_word;
  logic                  acc_rd;
  logic                  acc_wr;

  assign acc_rd  = bus.ce && !bus.we && !busy;
  assign acc_wr  = bus.ce && bus.we && !busy;
  assign rd_word = mem[bus.addr];

  always_comb begin
    merged = rd_word;
    for (int k = 0; k < WMASK_WIDTH; k++) begin
      if (bus.wmask[k]) begin
        merged[k*LW +: LW] = bus.din[k*LW +: LW];
      end
    end
  end

  // sweep owns the write port while busy
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign mem_we    = init_we || acc_wr;
  assign mem_addr  = init_we ? init_addr : bus.addr;
  assign mem_wdata = init_we ? '0 : merged;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end

  if (RDW_MODE == RDW_NEW) begin : g_rdw_new
    assign rdw_word = merged;
  end else if (RDW_MODE == RDW_OLD) begin : g_rdw_old
    assign rdw_word = rd_word;
  end else begin : g_rdw_x
    assign rdw_word = 'x;
  end

  logic                  s1_upd_d;
  logic                  s1_vld_d;
  logic [DATA_WIDTH-1:0] s1_data_d;

  always_comb begin
    s1_upd_d  = 1'b0;
    s1_vld_d  = 1'b0;
    s1_data_d = rd_word;
    unique case (1'b1)
      acc_rd: begin
        s1_upd_d = 1'b1;
        s1_vld_d = 1'b1;
      end
      acc_wr: begin
        s1_upd_d  = 1'b1;
        s1_vld_d  = (RDW_MODE != RDW_X);
        s1_data_d = rdw_word;
      end
      default: ;
    endcase
  end

  logic                  s1_upd;
  logic                  s1_vld;
  logic [DATA_WIDTH-1:0] s1_data;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      s1_upd  <= 1'b0;
      s1_vld  <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_upd <= s1_upd_d;
      s1_vld <= s1_vld_d;
      if (s1_upd_d) begin
        s1_data <= s1_data_d;
      end
    end
  end

  if (OUT_REG != 0) begin : g_oreg
    logic                  vld_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk or negedge rstb) begin
      if (!rstb) begin
        vld_q  <= 1'b0;
        data_q <= '0;
      end else begin
        vld_q <= s1_vld;
        if (s1_upd) begin
          data_q <= s1_data;
        end
      end
    end

    assign bus.dout       = data_q;
    assign bus.dout_valid = vld_q;
  end else begin : g_noreg
    logic unused_upd;
    assign unused_upd     = s1_upd;
    assign bus.dout       = s1_data;
    assign bus.dout_valid = s1_vld;
  end

  assign bus.busy = busy;

endmodule

// File: tb/tb_sram22_sram_model_pipelined.sv
// Bench for sram22_sram_model_pipelined: three configurations driven in
// lockstep, checked against a reference array and per-DUT scoreboards.
module tb_sram22_sram_model_pipelined;

  logic        clk = 1'b0;
  logic        rstb = 1'b1;
  logic        ce = 1'b0;
  logic        we = 1'b0;
  logic [3:0]  wmask = '0;
  logic [9:0]  addr = '0;
  logic [31:0] din = '0;

  always #5 clk = ~clk;

  sram22_sram_model_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WMASK_WIDTH(4)) ifa ();
  sram22_sram_model_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WMASK_WIDTH(4)) ifb ();
  sram22_sram_model_pipelined_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .WMASK_WIDTH(4)) ifc ();

  assign ifa.ce = ce;
  assign ifa.we = we;
  assign ifa.wmask = wmask;
  assign ifa.addr = addr;
  assign ifa.din = din;
  assign ifb.ce = ce;
  assign ifb.we = we;
  assign ifb.wmask = wmask;
  assign ifb.addr = addr;
  assign ifb.din = din;
  assign ifc.ce = ce;
  assign ifc.we = we;
  assign ifc.wmask = wmask;
  assign ifc.addr = addr;
  assign ifc.din = din;

  // a: 1-cycle, dout X on write; b: 2-cycle, old word; c: 1-cycle, new word
  sram22_sram_model_pipelined #(
    .OUT_REG(0), .RDW_MODE(0), .INIT_ON_RESET(1)
  ) dut_a (.clk(clk), .rstb(rstb), .bus(ifa));

  sram22_sram_model_pipelined #(
    .OUT_REG(1), .RDW_MODE(2), .INIT_ON_RESET(1)
  ) dut_b (.clk(clk), .rstb(rstb), .bus(ifb));

  sram22_sram_model_pipelined #(
    .OUT_REG(0), .RDW_MODE(1), .INIT_ON_RESET(1)
  ) dut_c (.clk(clk), .rstb(rstb), .bus(ifc));

  logic [31:0] dout_w [3];
  logic        dv_w [3];
  logic        bsy_w [3];

  assign dout_w[0] = ifa.dout;
  assign dout_w[1] = ifb.dout;
  assign dout_w[2] = ifc.dout;
  assign dv_w[0] = ifa.dout_valid;
  assign dv_w[1] = ifb.dout_valid;
  assign dv_w[2] = ifc.dout_valid;
  assign bsy_w[0] = ifa.busy;
  assign bsy_w[1] = ifb.busy;
  assign bsy_w[2] = ifc.busy;

  typedef struct {
    int          due;
    bit          vld;
    bit          upd;
    bit          known;
    logic [31:0] data;
  } exp_t;

  exp_t        sb [3][$];
  logic [31:0] last_d [3];
  bit          last_k [3];
  int          lat [3] = '{0, 1, 0};
  logic [31:0] mem_m [1024];
  int          init_left = 0;
  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;

  task automatic step(
    input bit          c,
    input bit          w,
    input logic [3:0]  m,
    input logic [9:0]  a,
    input logic [31:0] d
  );
    exp_t        e;
    logic [31:0] old;
    logic [31:0] mrg;
    bit          pv;
    bit          ebusy;
    ce = c;
    we = w;
    wmask = m;
    addr = a;
    din = d;
    cyc++;
    old = mem_m[a];
    mrg = old;
    for (int k = 0; k < 4; k++)
      if (m[k]) mrg[8*k +: 8] = d[8*k +: 8];
    for (int i = 0; i < 3; i++) begin
      e.due = cyc + lat[i];
      e.vld = 1'b0;
      e.upd = 1'b0;
      e.known = 1'b1;
      e.data = old;
      if (init_left == 0 && c && !w) begin
        e.vld = 1'b1;
        e.upd = 1'b1;
      end else if (init_left == 0 && c && w) begin
        e.upd = 1'b1;
        if (i == 0) begin
          e.known = 1'b0;
        end else begin
          e.vld = 1'b1;
          e.data = (i == 1) ? old : mrg;
        end
      end
      sb[i].push_back(e);
    end
    if (init_left > 0) init_left--;
    else if (c && w) mem_m[a] = mrg;
    ebusy = (init_left > 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      pv = 1'b0;
      if (sb[i].size() > 0 && sb[i][0].due == cyc) begin
        e = sb[i].pop_front();
        pv = e.vld;
        if (e.upd) begin
          last_d[i] = e.data;
          last_k[i] = e.known;
        end
      end
      tests++;
      if (dv_w[i] !== pv) begin
        fails++;
        $display("FAIL sb_valid dut%0d cyc %0d: got %b want %b",
                 i, cyc, dv_w[i], pv);
      end
      if (last_k[i]) begin
        tests++;
        if (dout_w[i] !== last_d[i]) begin
          fails++;
          $display("FAIL sb_dout dut%0d cyc %0d: got %h want %h",
                   i, cyc, dout_w[i], last_d[i]);
        end
      end
      tests++;
      if (bsy_w[i] !== ebusy) begin
        fails++;
        $display("FAIL busy dut%0d cyc %0d: got %b want %b",
                 i, cyc, bsy_w[i], ebusy);
      end
    end
  endtask

  task automatic do_reset();
    rstb = 1'b0;
    #2;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (dout_w[i] !== 32'h0 || dv_w[i] !== 1'b0 || bsy_w[i] !== 1'b1) begin
        fails++;
        $display("FAIL reset_out dut%0d: dout %h dv %b busy %b want 0 0 1",
                 i, dout_w[i], dv_w[i], bsy_w[i]);
      end
      sb[i].delete();
      last_d[i] = 32'h0;
      last_k[i] = 1'b1;
    end
    @(negedge clk);
    rstb = 1'b1;
    init_left = 1024;
    foreach (mem_m[j]) mem_m[j] = 32'h0;
  endtask

  task automatic test_reset();
    do_reset();
    for (int n = 0; n < 1024; n++)
      step(1'b1, 1'($urandom_range(0, 1)), 4'hF,
           10'($urandom_range(0, 1023)), $urandom);
    step(1'b1, 1'b0, 4'hF, 10'h3FF, 32'h0);
    tests++;
    if (dout_w[0] !== 32'h0 || dv_w[0] !== 1'b1) begin
      fails++;
      $display("FAIL read_3ff: dout %h dv %b want 0 1",
               dout_w[0], dv_w[0]);
    end
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic test_mask();
    step(1'b1, 1'b1, 4'b1111, 10'h005, 32'hDEADBEEF);
    step(1'b1, 1'b1, 4'b0101, 10'h005, 32'h11223344);
    step(1'b1, 1'b0, 4'h0, 10'h005, 32'h0);
    tests++;
    if (dout_w[2] !== 32'hDE22BE44 || dv_w[2] !== 1'b1) begin
      fails++;
      $display("FAIL mask_merge: dout %h dv %b want de22be44 1",
               dout_w[2], dv_w[2]);
    end
    step(1'b1, 1'b1, 4'b0000, 10'h005, 32'h99999999);
    step(1'b1, 1'b0, 4'h0, 10'h005, 32'h0);
    tests++;
    if (dout_w[0] !== 32'hDE22BE44) begin
      fails++;
      $display("FAIL mask_zero: dout %h want de22be44", dout_w[0]);
    end
  endtask

  task automatic test_pipeline();
    step(1'b1, 1'b1, 4'hF, 10'h001, 32'h1);
    step(1'b1, 1'b1, 4'hF, 10'h002, 32'h2);
    step(1'b1, 1'b1, 4'hF, 10'h003, 32'h3);
    step(1'b1, 1'b0, 4'h0, 10'h001, 32'h0);
    step(1'b1, 1'b0, 4'h0, 10'h002, 32'h0);
    tests++;
    if (dout_w[1] !== 32'h1 || dv_w[1] !== 1'b1) begin
      fails++;
      $display("FAIL pipe_1: dout %h dv %b want 1 1", dout_w[1], dv_w[1]);
    end
    step(1'b1, 1'b0, 4'h0, 10'h003, 32'h0);
    tests++;
    if (dout_w[1] !== 32'h2 || dv_w[1] !== 1'b1) begin
      fails++;
      $display("FAIL pipe_2: dout %h dv %b want 2 1", dout_w[1], dv_w[1]);
    end
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    tests++;
    if (dout_w[1] !== 32'h3 || dv_w[1] !== 1'b1) begin
      fails++;
      $display("FAIL pipe_3: dout %h dv %b want 3 1", dout_w[1], dv_w[1]);
    end
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    tests++;
    if (dout_w[1] !== 32'h3 || dv_w[1] !== 1'b0) begin
      fails++;
      $display("FAIL pipe_end: dout %h dv %b want 3 0", dout_w[1], dv_w[1]);
    end
  endtask

  task automatic test_rdw();
    step(1'b1, 1'b1, 4'hF, 10'h010, 32'hAAAA5555);
    step(1'b1, 1'b1, 4'hF, 10'h010, 32'h12345678);
    tests++;
    if (dout_w[2] !== 32'h12345678 || dv_w[2] !== 1'b1 || dv_w[0] !== 1'b0) begin
      fails++;
      $display("FAIL rdw_new_x: c %h/%b a_dv %b want 12345678/1 0",
               dout_w[2], dv_w[2], dv_w[0]);
    end
    step(1'b1, 1'b0, 4'h0, 10'h010, 32'h0);
    tests++;
    if (dout_w[1] !== 32'hAAAA5555 || dv_w[1] !== 1'b1) begin
      fails++;
      $display("FAIL rdw_old: dout %h dv %b want aaaa5555 1",
               dout_w[1], dv_w[1]);
    end
    tests++;
    if (dout_w[0] !== 32'h12345678 || dv_w[0] !== 1'b1) begin
      fails++;
      $display("FAIL rdw_readback: dout %h dv %b want 12345678 1",
               dout_w[0], dv_w[0]);
    end
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    tests++;
    if (dout_w[1] !== 32'h12345678) begin
      fails++;
      $display("FAIL rdw_old_next: dout %h want 12345678", dout_w[1]);
    end
  endtask

  task automatic test_idle();
    step(1'b1, 1'b1, 4'hF, 10'h007, 32'hCAFE0007);
    step(1'b1, 1'b0, 4'h0, 10'h007, 32'h0);
    for (int n = 0; n < 3; n++) begin
      step(1'b0, 1'(n % 2 == 0), 4'hF, 10'h007, $urandom);
      tests++;
      if (dout_w[0] !== 32'hCAFE0007 || dv_w[0] !== 1'b0) begin
        fails++;
        $display("FAIL idle_hold %0d: dout %h dv %b want cafe0007 0",
                 n, dout_w[0], dv_w[0]);
      end
    end
    step(1'b1, 1'b0, 4'h0, 10'h007, 32'h0);
    tests++;
    if (dout_w[2] !== 32'hCAFE0007 || dv_w[2] !== 1'b1) begin
      fails++;
      $display("FAIL idle_array: dout %h dv %b want cafe0007 1",
               dout_w[2], dv_w[2]);
    end
  endtask

  task automatic test_back_to_back();
    for (int n = 0; n < 300; n++)
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
           4'($urandom), 10'($urandom_range(0, 15)), $urandom);
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
  endtask

  task automatic test_reset_mid_init();
    do_reset();
    for (int n = 0; n < 500; n++)
      step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    do_reset();
    for (int n = 0; n < 1023; n++)
      step(1'b1, 1'b0, 4'h0, 10'($urandom), 32'h0);
    tests++;
    if (bsy_w[0] !== 1'b1) begin
      fails++;
      $display("FAIL restart_busy: got %b want 1", bsy_w[0]);
    end
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    tests++;
    if (bsy_w[1] !== 1'b0) begin
      fails++;
      $display("FAIL restart_done: got %b want 0", bsy_w[1]);
    end
  endtask

  task automatic test_reset_mid_read();
    step(1'b1, 1'b1, 4'hF, 10'h020, 32'h55AA55AA);
    step(1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    do_reset();
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    tests++;
    if (dv_w[1] !== 1'b0 || dout_w[1] !== 32'h0) begin
      fails++;
      $display("FAIL inflight_drop: dout %h dv %b want 0 0",
               dout_w[1], dv_w[1]);
    end
    for (int n = 0; n < 1023; n++)
      step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    step(1'b1, 1'b0, 4'h0, 10'h020, 32'h0);
    step(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    tests++;
    if (dout_w[1] !== 32'h0 || dv_w[1] !== 1'b1) begin
      fails++;
      $display("FAIL reinit_zero: dout %h dv %b want 0 1",
               dout_w[1], dv_w[1]);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_mask();
    test_pipeline();
    test_rdw();
    test_idle();
    test_back_to_back();
    test_reset_mid_init();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
